// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_SNAP    = 3'd3;
  localparam logic [2:0] REG_PRESC   = 3'd4;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus shared by all timer channels.
interface avalon_multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) ();
  localparam int ADDR_W = $clog2(NUM_CH) + 3;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: prescaler, counter, control/status and snapshot.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int PRESC_W        = 16,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_status,
  input  logic               wr_control,
  input  logic               wr_period,
  input  logic               wr_snap,
  input  logic               wr_presc,
  input  logic [3:0]         ctl_wdata,
  input  logic [CNT_W-1:0]   period_wdata,
  input  logic [PRESC_W-1:0] presc_wdata,
  output logic               run,
  output logic               to,
  output logic               ito,
  output logic               cont,
  output logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   snapshot,
  output logic [PRESC_W-1:0] presc,
  output logic               timeout_pulse
);

  logic               run_reg, to_reg, ito_reg, cont_reg, pulse_reg;
  logic [CNT_W-1:0]   period_reg, counter_reg, snap_reg;
  logic [PRESC_W-1:0] presc_reg, presc_cnt_reg;

  logic tick, wrap, start, stop;

  assign tick  = run_reg & (presc_cnt_reg == '0);
  // A period write overrides the counter, so it also swallows a coincident wrap.
  assign wrap  = tick & (counter_reg == '0) & ~wr_period;
  assign start = wr_control & ctl_wdata[CTL_START];
  assign stop  = wr_control & ctl_wdata[CTL_STOP];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg       <= 1'b0;
      to_reg        <= 1'b0;
      ito_reg       <= 1'b0;
      cont_reg      <= 1'b0;
      pulse_reg     <= 1'b0;
      period_reg    <= CNT_W'(DEFAULT_PERIOD);
      counter_reg   <= CNT_W'(DEFAULT_PERIOD);
      snap_reg      <= '0;
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
    end else begin
      pulse_reg <= wrap;

      if (wr_period) period_reg <= period_wdata;
      if (wr_presc)  presc_reg  <= presc_wdata;
      if (wr_snap)   snap_reg   <= counter_reg;
      if (wr_control) begin
        ito_reg  <= ctl_wdata[CTL_ITO];
        cont_reg <= ctl_wdata[CTL_CONT];
      end

      if (wr_period)
        counter_reg <= period_wdata;
      else if (tick)
        counter_reg <= (counter_reg == '0) ? period_reg : counter_reg - 1'b1;

      if (start || wr_period || presc_cnt_reg == '0)
        presc_cnt_reg <= presc_reg;
      else
        presc_cnt_reg <= presc_cnt_reg - 1'b1;

      // Set wins over a simultaneous software clear so no timeout is lost.
      if (wrap)
        to_reg <= 1'b1;
      else if (wr_status)
        to_reg <= 1'b0;

      if (wr_period)
        run_reg <= 1'b0;
      else if (start)
        run_reg <= 1'b1;
      else if (stop || (wrap && !cont_reg))
        run_reg <= 1'b0;
    end
  end

  assign run           = run_reg;
  assign to            = to_reg;
  assign ito           = ito_reg;
  assign cont          = cont_reg;
  assign period        = period_reg;
  assign snapshot      = snap_reg;
  assign presc         = presc_reg;
  assign timeout_pulse = pulse_reg;

endmodule

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent interval timers behind one Avalon-MM slave with a shared IRQ.
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DATA_W         = 32,
  parameter int PRESC_W        = 16,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset,
  avalon_multi_timer_if.slave bus,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] timeout_pulse
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_sel;
  logic [2:0]        reg_sel;
  logic              wr;
  logic [NUM_CH-1:0] ch_hit;
  logic [DATA_W-1:0] ch_rdata [NUM_CH];
  logic [DATA_W-1:0] readdata_next, readdata_reg;

  assign reg_sel = bus.address[2:0];
  assign wr      = bus.chipselect & ~bus.write_n;

  generate
    if (NUM_CH > 1) begin : g_ch_dec
      assign ch_sel = bus.address[CH_W+2:3];
    end else begin : g_ch_single
      assign ch_sel = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic               run, to, ito, cont;
      logic [CNT_W-1:0]   period, snapshot;
      logic [PRESC_W-1:0] presc;
      logic               wr_ch;
      logic [DATA_W-1:0]  rdata;

      // Channel indices >= NUM_CH never match, so they read 0 and ignore writes.
      assign ch_hit[gi] = (ch_sel == CH_W'(gi));
      assign wr_ch      = wr & ch_hit[gi];

      timer_channel #(
        .CNT_W          (CNT_W),
        .PRESC_W        (PRESC_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_channel (
        .clk           (clk),
        .reset         (reset),
        .wr_status     (wr_ch && reg_sel == REG_STATUS),
        .wr_control    (wr_ch && reg_sel == REG_CONTROL),
        .wr_period     (wr_ch && reg_sel == REG_PERIOD),
        .wr_snap       (wr_ch && reg_sel == REG_SNAP),
        .wr_presc      (wr_ch && reg_sel == REG_PRESC),
        .ctl_wdata     (bus.writedata[3:0]),
        .period_wdata  (bus.writedata[CNT_W-1:0]),
        .presc_wdata   (bus.writedata[PRESC_W-1:0]),
        .run           (run),
        .to            (to),
        .ito           (ito),
        .cont          (cont),
        .period        (period),
        .snapshot      (snapshot),
        .presc         (presc),
        .timeout_pulse (timeout_pulse[gi])
      );

      always_comb begin
        rdata = '0;
        case (reg_sel)
          REG_STATUS: begin
            rdata[STS_RUN] = run;
            rdata[STS_TO]  = to;
          end
          REG_CONTROL: begin
            rdata[CTL_CONT] = cont;
            rdata[CTL_ITO]  = ito;
          end
          REG_PERIOD: rdata = DATA_W'(period);
          REG_SNAP:   rdata = DATA_W'(snapshot);
          REG_PRESC:  rdata = DATA_W'(presc);
          default:    rdata = '0;
        endcase
      end

      assign ch_rdata[gi] = rdata;
      assign irq_vec[gi]  = to & ito;
    end
  endgenerate

  always_comb begin
    readdata_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) readdata_next = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_reg <= '0;
    else       readdata_reg <= readdata_next;
  end

  assign bus.readdata = readdata_reg;
  assign irq          = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer: a 4-channel and a 3-channel instance.
module tb_avalon_multi_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  avalon_multi_timer_if #(.NUM_CH(4), .DATA_W(32)) bus4 ();
  avalon_multi_timer_if #(.NUM_CH(3), .DATA_W(32)) bus3 ();

  logic       irq4, irq3;
  logic [3:0] vec4, tp4;
  logic [2:0] vec3, tp3;

  avalon_multi_timer #(.NUM_CH(4)) dut (
    .clk (clk), .reset (reset), .bus (bus4),
    .irq (irq4), .irq_vec (vec4), .timeout_pulse (tp4)
  );

  avalon_multi_timer #(.NUM_CH(3)) dut3 (
    .clk (clk), .reset (reset), .bus (bus3),
    .irq (irq3), .irq_vec (vec3), .timeout_pulse (tp3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bus tasks are called at a negedge and return one cycle later at the next negedge.
  task automatic bus_wr(input bit sel3, input int ch, input int rg, input logic [31:0] d);
    if (sel3) begin
      bus3.address = 5'(ch * 8 + rg); bus3.chipselect = 1'b1; bus3.write_n = 1'b0; bus3.writedata = d;
    end else begin
      bus4.address = 5'(ch * 8 + rg); bus4.chipselect = 1'b1; bus4.write_n = 1'b0; bus4.writedata = d;
    end
    @(negedge clk);
    bus3.chipselect = 1'b0; bus3.write_n = 1'b1;
    bus4.chipselect = 1'b0; bus4.write_n = 1'b1;
    $display("WR dut%0d ch%0d reg%0d <= %0d", sel3 ? 3 : 4, ch, rg, d);
  endtask

  task automatic rd_check(input bit sel3, input int ch, input int rg, input string tag,
                          input logic [31:0] exp);
    logic [31:0] d;
    if (sel3) bus3.address = 5'(ch * 8 + rg);
    else      bus4.address = 5'(ch * 8 + rg);
    @(negedge clk);
    d = sel3 ? bus3.readdata : bus4.readdata;
    $display("RD dut%0d ch%0d reg%0d -> %0d", sel3 ? 3 : 4, ch, rg, d);
    check(tag, d, exp);
  endtask

  initial begin
    bus4.address = '0; bus4.chipselect = 1'b0; bus4.write_n = 1'b1; bus4.writedata = '0;
    bus3.address = '0; bus3.chipselect = 1'b0; bus3.write_n = 1'b1; bus3.writedata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_irq", {31'd0, irq4}, 32'd0);
    check("rst_tp", {28'd0, tp4}, 32'd0);
    check("rst_vec", {28'd0, vec4}, 32'd0);
    check("rst_rdata", bus4.readdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_check(0, 0, 2, "rst_period", 32'd49999);
    rd_check(0, 0, 0, "rst_status", 32'd0);
    rd_check(0, 0, 4, "rst_presc", 32'd0);

    // ch0: PERIOD=4, PRESC=0, continuous -> pulse every 5 cycles, irq masked
    bus_wr(0, 0, 2, 32'd4);
    bus_wr(0, 0, 4, 32'd0);
    bus_wr(0, 0, 1, 32'd6);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("ch0_pulse_k%0d", k), {31'd0, tp4[0]}, {31'd0, (k % 5 == 0)});
      check($sformatf("ch0_irq_k%0d", k), {31'd0, irq4}, 32'd0);
    end
    rd_check(0, 0, 0, "ch0_status", 32'd3);
    bus_wr(0, 0, 1, 32'd3);
    check("ch0_irq_ito", {31'd0, irq4}, 32'd1);
    bus_wr(0, 0, 1, 32'd11);
    bus_wr(0, 0, 0, 32'd0);
    check("ch0_irq_clr", {31'd0, irq4}, 32'd0);

    // ch1: PERIOD=1, PRESC=2, one-shot -> single pulse 6 cycles after start
    bus_wr(0, 1, 2, 32'd1);
    bus_wr(0, 1, 4, 32'd2);
    bus_wr(0, 1, 1, 32'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("ch1_pulse_k%0d", k), {31'd0, tp4[1]}, {31'd0, (k == 6)});
    end
    rd_check(0, 1, 0, "ch1_status", 32'd1);
    bus_wr(0, 1, 3, 32'd0);
    rd_check(0, 1, 3, "ch1_reload", 32'd1);

    // ch2: STATUS write coinciding with a timeout keeps TO set
    bus_wr(0, 2, 2, 32'd3);
    bus_wr(0, 2, 1, 32'd7);
    repeat (3) @(negedge clk);
    check("ch2_irq_pre", {31'd0, irq4}, 32'd0);
    bus_wr(0, 2, 0, 32'd0);
    check("ch2_pulse_col", {31'd0, tp4[2]}, 32'd1);
    check("ch2_irq_col", {31'd0, irq4}, 32'd1);
    check("ch2_vec_col", {28'd0, vec4}, 32'd4);
    bus_wr(0, 2, 1, 32'd9);
    check("ch2_irq_stop", {31'd0, irq4}, 32'd1);
    bus_wr(0, 2, 0, 32'd0);
    check("ch2_irq_clr", {31'd0, irq4}, 32'd0);
    check("ch2_vec_clr", {28'd0, vec4}, 32'd0);

    // ch3: snapshot while running, then PERIOD write reloads and stops
    bus_wr(0, 3, 2, 32'd100);
    bus_wr(0, 3, 1, 32'd4);
    repeat (63) @(negedge clk);
    bus_wr(0, 3, 3, 32'd0);
    rd_check(0, 3, 3, "ch3_snap37", 32'd37);
    bus_wr(0, 3, 2, 32'd10);
    bus_wr(0, 3, 3, 32'd0);
    rd_check(0, 3, 3, "ch3_snap10", 32'd10);
    rd_check(0, 3, 0, "ch3_status", 32'd0);
    bus_wr(0, 3, 1, 32'd12);
    rd_check(0, 3, 0, "ch3_startstop", 32'd2);
    bus_wr(0, 3, 1, 32'd8);
    rd_check(0, 3, 0, "ch3_stopped", 32'd0);
    rd_check(0, 3, 1, "ch3_ctl_pulses", 32'd0);

    // 3-channel build: unused offsets and missing channel
    bus_wr(1, 0, 5, 32'd7);
    rd_check(1, 0, 5, "d3_reg5", 32'd0);
    bus_wr(1, 3, 2, 32'd7);
    bus_wr(1, 3, 1, 32'd4);
    rd_check(1, 3, 2, "d3_ch3_period", 32'd0);
    rd_check(1, 0, 2, "d3_ch0_period", 32'd49999);
    rd_check(1, 2, 2, "d3_ch2_period", 32'd49999);
    rd_check(1, 0, 0, "d3_ch0_status", 32'd0);
    check("d3_irq", {31'd0, irq3}, 32'd0);

    // Reset mid-count clears outputs without waiting for a clock edge
    bus_wr(0, 0, 2, 32'd2);
    bus_wr(0, 0, 1, 32'd7);
    repeat (3) @(negedge clk);
    check("mid_pulse_pre", {31'd0, tp4[0]}, 32'd1);
    check("mid_irq_pre", {31'd0, irq4}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_irq", {31'd0, irq4}, 32'd0);
    check("mid_vec", {28'd0, vec4}, 32'd0);
    check("mid_tp", {28'd0, tp4}, 32'd0);
    check("mid_rdata", bus4.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_check(0, 0, 2, "post_period", 32'd49999);
    rd_check(0, 0, 0, "post_status", 32'd0);
    rd_check(0, 0, 1, "post_control", 32'd0);
    repeat (5) @(negedge clk);
    check("post_tp", {28'd0, tp4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
